// File: rtl/ro_puf_pkg.sv
// Shared types and helpers for the RO-PUF pair measurement engine.
// FSM state encoding, default settle length, saturating increment.
`timescale 1ns/1ps
package ro_puf_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_RUN,
    S_SETTLE,
    S_CMP,
    S_DONE
  } state_e;

  localparam int SETTLE_DEF = 4;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input logic [31:0] max_v
  );
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ro_ring.sv
// Single ring oscillator: NAND enable gate plus STAGES-1 inverters.
// Ports: en (1 = oscillate), ro_out (held 0 while en=0).
`timescale 1ns/1ps
module ro_ring #(
  parameter int STAGES = 5,
  parameter int DLY    = 1
) (
  input  logic en,
  output logic ro_out
);

  logic s [STAGES];

`ifdef SYNTHESIS
  assign s[0] = ~(en & s[STAGES-1]);
  for (genvar k = 1; k < STAGES; k++) begin : g_inv
    assign s[k] = ~s[k-1];
  end
`else
  // Per-stage delay gives the loop a finite period in simulation.
  assign #(DLY) s[0] = ~(en & s[STAGES-1]);
  for (genvar k = 1; k < STAGES; k++) begin : g_inv
    assign #(DLY) s[k] = ~s[k-1];
  end
`endif

  // Odd number of inversions after the gate: reads 0 when disabled.
  assign ro_out = s[STAGES-2];

endmodule

// File: rtl/ro_puf_pair_meas.sv
// RO-PUF pair measurement: runs two selected rings for a fixed window,
// counts their rising edges and reports which ring was faster.
// Ports: clk, rst (sync, active-high), start, sel_a, sel_b in;
//        busy, done, resp, tie, err, cnt_a, cnt_b out.
`timescale 1ns/1ps
module ro_puf_pair_meas
  import ro_puf_pkg::*;
#(
  parameter int NUM_RO         = 8,
  parameter int STAGES         = 5,
  parameter int SEL_W          = 3,
  parameter int CNT_W          = 16,
  parameter int WINDOW         = 16,
  parameter int SETTLE         = SETTLE_DEF,
  parameter int STAGE_DLY_BASE = 1,
  parameter int SIM_SKEW       = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SEL_W-1:0] sel_a,
  input  logic [SEL_W-1:0] sel_b,
  output logic             busy,
  output logic             done,
  output logic             resp,
  output logic             tie,
  output logic             err,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  localparam logic [31:0] CNT_MAX =
    32'((64'd1 << CNT_W) - 64'd1);
  localparam int SEL_N = 2 ** SEL_W;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sa_q, sa_d;
  logic [SEL_W-1:0] sb_q, sb_d;
  logic [15:0]      tmr_q, tmr_d;
  logic [NUM_RO-1:0] en_q, en_d;
  logic             clr_q, clr_d;
  logic             resp_q, resp_d;
  logic             tie_q, tie_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] ca_q, ca_d;
  logic [CNT_W-1:0] cb_q, cb_d;

  logic [NUM_RO-1:0] run_mask;
  logic              illegal_w;
  logic [NUM_RO-1:0] ro_w;
  logic [SEL_N-1:0]  ro_pad;
  logic              ro_a, ro_b;
  logic [CNT_W-1:0]  rc_a_q, rc_b_q;

  assign illegal_w = (sel_a == sel_b)
    || (32'(sel_a) >= 32'(NUM_RO))
    || (32'(sel_b) >= 32'(NUM_RO));

  always_comb begin
    run_mask = '0;
    for (int i = 0; i < NUM_RO; i++) begin
      run_mask[i] = (32'(sa_q) == i) || (32'(sb_q) == i);
    end
  end

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    tmr_d   = tmr_q;
    en_d    = '0;
    clr_d   = 1'b0;
    resp_d  = resp_q;
    tie_d   = tie_q;
    err_d   = err_q;
    ca_d    = ca_q;
    cb_d    = cb_q;
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE);
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          sa_d   = sel_a;
          sb_d   = sel_b;
          resp_d = 1'b0;
          tie_d  = 1'b0;
          ca_d   = '0;
          cb_d   = '0;
          err_d  = illegal_w;
          clr_d  = !illegal_w;
          state_d = illegal_w ? S_DONE : S_CLR;
        end
      end
      S_CLR: begin
        tmr_d   = '0;
        en_d    = run_mask;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (tmr_q == 16'(WINDOW - 1)) begin
          tmr_d   = '0;
          state_d = S_SETTLE;
        end else begin
          tmr_d = tmr_q + 16'd1;
          en_d  = run_mask;
        end
      end
      S_SETTLE: begin
        if (tmr_q == 16'(SETTLE - 1)) begin
          state_d = S_CMP;
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end
      S_CMP: begin
        ca_d    = rc_a_q;
        cb_d    = rc_b_q;
        resp_d  = (rc_a_q > rc_b_q);
        tie_d   = (rc_a_q == rc_b_q);
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      tmr_q   <= '0;
      en_q    <= '0;
      // Hold the ring counters cleared while in reset.
      clr_q   <= 1'b1;
      resp_q  <= 1'b0;
      tie_q   <= 1'b0;
      err_q   <= 1'b0;
      ca_q    <= '0;
      cb_q    <= '0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      tmr_q   <= tmr_d;
      en_q    <= en_d;
      clr_q   <= clr_d;
      resp_q  <= resp_d;
      tie_q   <= tie_d;
      err_q   <= err_d;
      ca_q    <= ca_d;
      cb_q    <= cb_d;
    end
  end

  assign resp  = resp_q;
  assign tie   = tie_q;
  assign err   = err_q;
  assign cnt_a = ca_q;
  assign cnt_b = cb_q;

  for (genvar i = 0; i < NUM_RO; i++) begin : g_ring
    ro_ring #(
      .STAGES (STAGES),
      .DLY    (STAGE_DLY_BASE + i * SIM_SKEW)
    ) u_ring (
      .en     (en_q[i]),
      .ro_out (ro_w[i])
    );
  end

  // Selects only change in IDLE while every ring is parked at 0,
  // so the muxed counter clocks never see a select-induced edge.
  assign ro_pad = SEL_N'(ro_w);
  assign ro_a   = ro_pad[sa_q];
  assign ro_b   = ro_pad[sb_q];

  always_ff @(posedge ro_a or posedge clr_q) begin
    if (clr_q) begin
      rc_a_q <= '0;
    end else begin
      rc_a_q <= CNT_W'(sat_inc(32'(rc_a_q), CNT_MAX));
    end
  end

  always_ff @(posedge ro_b or posedge clr_q) begin
    if (clr_q) begin
      rc_b_q <= '0;
    end else begin
      rc_b_q <= CNT_W'(sat_inc(32'(rc_b_q), CNT_MAX));
    end
  end

endmodule

// File: tb/tb_ro_puf_pair_meas.sv
// Bench for ro_puf_pair_meas: three configurations share one stimulus
// stream and are checked against an edge-counting waveform model.
`timescale 1ns/1ps
module tb_ro_puf_pair_meas;

  localparam int STG    = 5;
  localparam int WIN    = 16;
  localparam int WIN_NS = WIN * 100;
  localparam int DONE_C = 3 + WIN + 4;

  logic clk = 1'b0;
  logic rst, start;
  logic [2:0] sel_a, sel_b;

  logic [2:0] busy_w, done_w, resp_w, tie_w, err_w;
  logic [15:0] ca_w [3];
  logic [15:0] cb_w [3];
  logic [15:0] c0a, c0b, c1a, c1b;
  logic [5:0]  c2a, c2b;

  int nro  [3] = '{6, 8, 8};
  int skew [3] = '{0, 1, 0};
  int cw   [3] = '{16, 16, 6};

  int checks = 0;
  int errors = 0;
  logic [7:0] seen;

  always #50 clk = ~clk;

  ro_puf_pair_meas #(.NUM_RO(6), .SIM_SKEW(0)) u0 (
    .clk(clk), .rst(rst), .start(start),
    .sel_a(sel_a), .sel_b(sel_b),
    .busy(busy_w[0]), .done(done_w[0]), .resp(resp_w[0]),
    .tie(tie_w[0]), .err(err_w[0]),
    .cnt_a(c0a), .cnt_b(c0b)
  );

  ro_puf_pair_meas #(.NUM_RO(8), .SIM_SKEW(1)) u1 (
    .clk(clk), .rst(rst), .start(start),
    .sel_a(sel_a), .sel_b(sel_b),
    .busy(busy_w[1]), .done(done_w[1]), .resp(resp_w[1]),
    .tie(tie_w[1]), .err(err_w[1]),
    .cnt_a(c1a), .cnt_b(c1b)
  );

  ro_puf_pair_meas #(.NUM_RO(8), .CNT_W(6), .SIM_SKEW(0)) u2 (
    .clk(clk), .rst(rst), .start(start),
    .sel_a(sel_a), .sel_b(sel_b),
    .busy(busy_w[2]), .done(done_w[2]), .resp(resp_w[2]),
    .tie(tie_w[2]), .err(err_w[2]),
    .cnt_a(c2a), .cnt_b(c2b)
  );

  assign ca_w[0] = c0a;
  assign cb_w[0] = c0b;
  assign ca_w[1] = c1a;
  assign cb_w[1] = c1b;
  assign ca_w[2] = {10'd0, c2a};
  assign cb_w[2] = {10'd0, c2b};

  always @(u1.ro_w) seen = seen | u1.ro_w;

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic bit illegal(int k, int a, int b);
    return (a == b) || (a >= nro[k]) || (b >= nro[k]);
  endfunction

  // Rising edges of a ring enabled for WIN_NS: stage delay d,
  // period 2*STG*d, first rise after STG-1 stage delays.
  function automatic int exp_cnt(int k, int r);
    int d, per, first, n, mx;
    d     = 1 + r * skew[k];
    per   = 2 * STG * d;
    first = (STG - 1) * d;
    n     = (WIN_NS > first) ? (WIN_NS - first - 1) / per + 1 : 0;
    mx    = (1 << cw[k]) - 1;
    return (n > mx) ? mx : n;
  endfunction

  function automatic bit near(longint g, longint e);
    return (g >= e - 1) && (g <= e + 1);
  endfunction

  task automatic run_txn(input int a, input int b, input bit hammer);
    int nd [3];
    int dc [3];
    logic [15:0] ra [3];
    logic [15:0] rb [3];
    logic rr [3];
    logic rt [3];
    logic re [3];
    int ea, eb;
    bit e;
    logic [7:0] mask;
    for (int k = 0; k < 3; k++) begin
      nd[k] = 0; dc[k] = 0;
      ra[k] = '0; rb[k] = '0;
      rr[k] = 0; rt[k] = 0; re[k] = 0;
    end
    @(negedge clk);
    sel_a = 3'(a);
    sel_b = 3'(b);
    start = 1'b1;
    seen  = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) chk("busy_acc", busy_w, 3'b111);
      start = hammer && (c < DONE_C - 1);
      for (int k = 0; k < 3; k++) begin
        if (done_w[k]) begin
          nd[k]++;
          dc[k] = c;
          ra[k] = ca_w[k];
          rb[k] = cb_w[k];
          rr[k] = resp_w[k];
          rt[k] = tie_w[k];
          re[k] = err_w[k];
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      e  = illegal(k, a, b);
      ea = e ? 0 : exp_cnt(k, a);
      eb = e ? 0 : exp_cnt(k, b);
      chk($sformatf("u%0d n_done %0d/%0d", k, a, b), nd[k], 1);
      chk($sformatf("u%0d done_cyc", k), dc[k], e ? 1 : DONE_C);
      chk($sformatf("u%0d err", k), re[k], e);
      if (e) begin
        chk($sformatf("u%0d cnt_a", k), ra[k], 0);
        chk($sformatf("u%0d cnt_b", k), rb[k], 0);
        chk($sformatf("u%0d resp", k), rr[k], 0);
        chk($sformatf("u%0d tie", k), rt[k], 0);
      end else begin
        chk($sformatf("u%0d cnt_a=%0d~%0d", k, ra[k], ea),
            near(ra[k], ea), 1);
        chk($sformatf("u%0d cnt_b=%0d~%0d", k, rb[k], eb),
            near(rb[k], eb), 1);
        if (skew[k] == 0) begin
          // Identical rings started together count identically.
          chk($sformatf("u%0d tie", k), rt[k], 1);
          chk($sformatf("u%0d resp", k), rr[k], 0);
        end else begin
          chk($sformatf("u%0d tie", k), rt[k], 0);
          chk($sformatf("u%0d resp", k), rr[k], ea > eb);
        end
      end
    end
    mask = illegal(1, a, b) ? 8'h00 : 8'((1 << a) | (1 << b));
    chk("ro_idle", seen & ~mask, 0);
    chk("ro_seen", seen, mask);
  endtask

  task automatic run_reset(input int a, input int b);
    int nd;
    nd = 0;
    @(negedge clk);
    sel_a = 3'(a);
    sel_b = 3'(b);
    start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    chk("rst_busy", busy_w, 0);
    chk("rst_done", done_w, 0);
    chk("rst_resp", resp_w, 0);
    chk("rst_tie", tie_w, 0);
    chk("rst_err", err_w, 0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_cnt u%0d", k), {ca_w[k], cb_w[k]}, 0);
    end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done_w != 0) nd++;
    end
    chk("rst_nodone", nd, 0);
  endtask

  initial begin
    int a, b;
    bit h;
    rst   = 1'b1;
    start = 1'b0;
    sel_a = '0;
    sel_b = '0;
    seen  = '0;
    repeat (3) @(negedge clk);
    chk("init_busy", busy_w, 0);
    chk("init_done", done_w, 0);
    chk("init_resp", resp_w, 0);
    chk("init_tie", tie_w, 0);
    chk("init_err", err_w, 0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("init_cnt u%0d", k), {ca_w[k], cb_w[k]}, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy_w, 0);

    run_txn(0, 1, 0);
    run_txn(0, 3, 0);
    run_txn(3, 0, 0);
    run_txn(2, 2, 0);
    run_txn(7, 1, 0);
    run_reset(0, 1);
    run_txn(1, 2, 0);
    run_txn(4, 5, 1);

    for (int i = 0; i < 12; i++) begin
      a = int'($urandom_range(0, 7));
      b = int'($urandom_range(0, 7));
      h = (a < 6 && b < 6 && a != b) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_txn(a, b, h);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
